// File: rtl/mips_pkg.sv
// mips_pkg: loader state encoding and instruction-memory geometry shared by the loader.
package mips_pkg;
    localparam int INST_MEM_WORDS = 32;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, DONE, ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        , CHECK
`endif
    } loader_state_t;
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: shifts bytes MSB-first into a 32-bit word; word_valid marks the 4th byte.
module byte_assembler
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [23:0] acc;
    logic [1:0]  cnt;

    assign word_valid = shift_en && cnt == 2'(WORD_BYTES - 1);
    assign word = {acc, byte_data};

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            acc <= {acc[15:0], byte_data};
            cnt <= cnt + 2'd1;
        end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte stream to instruction-memory writes, holding the CPU until loaded.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = INST_MEM_WORDS,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             load_enable,
    output logic [31:0]      write_addr,
    output logic [31:0]      write_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);
    localparam logic [7:0] MAX_N = 8'(MEM_WORDS);

    loader_state_t state, state_n;
    logic [CNT_W-1:0] n_words, word_idx;
    logic [31:0] word;
    logic accept, clear, word_valid, is_last;

    assign accept = byte_valid && byte_ready;
    assign clear = start && (state == IDLE || state == DONE || state == ERR);
    // word_idx counts words already handed to the write registers
    assign is_last = word_idx == n_words;
    assign words_loaded = word_idx;
    assign cpu_hold = state != DONE;
    assign done = state == DONE;
    assign error = state == ERR;

    byte_assembler u_asm (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .shift_en  (accept && state == DATA),
        .byte_data (byte_data),
        .word_valid(word_valid),
        .word      (word)
    );

    always_comb begin
        byte_ready = state == COUNT || (state == DATA && !is_last);
`ifdef PROG_LOADER_CHECKSUM_EN
        byte_ready = byte_ready || state == CHECK;
`endif
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) xor_acc <= '0;
        else if (clear) xor_acc <= '0;
        else if (accept && state == DATA) xor_acc <= xor_acc ^ byte_data;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: state_n = start ? COUNT : state;
            COUNT: if (accept) state_n = (byte_data == 8'd0 || byte_data > MAX_N) ? ERR : DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            DATA: if (load_enable && is_last) state_n = CHECK;
            CHECK: if (accept) state_n = (byte_data == xor_acc) ? DONE : ERR;
`else
            DATA: if (load_enable && is_last) state_n = DONE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            n_words <= '0;
            word_idx <= '0;
            load_enable <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            state <= state_n;
            load_enable <= word_valid;
            if (clear) word_idx <= '0;
            else if (word_valid) word_idx <= word_idx + 1'b1;
            if (accept && state == COUNT) n_words <= byte_data[CNT_W-1:0];
            if (word_valid) begin
                write_data <= word;
                write_addr <= {{(30-CNT_W){1'b0}}, word_idx, 2'b00};
            end
        end
endmodule
